// File: rtl/wb_burst_ram_if.sv
// Wishbone B4 bus bundle between a master and the wb_burst_ram slave.
// Signal names keep the slave's point of view (_i into the RAM, _o out of it).
interface wb_burst_ram_if #(
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = DATA_WIDTH / 8
);
    logic [ADDR_WIDTH-1:0] adr_i;
    logic [DATA_WIDTH-1:0] dat_i;
    logic [DATA_WIDTH-1:0] dat_o;
    logic                  we_i;
    logic [SEL_WIDTH-1:0]  sel_i;
    logic                  stb_i;
    logic                  cyc_i;
    logic [2:0]            cti_i;
    logic [1:0]            bte_i;
    logic                  ack_o;
    logic                  err_o;

    modport master (
        output adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
        input  dat_o, ack_o, err_o
    );

    modport slave (
        input  adr_i, dat_i, we_i, sel_i, stb_i, cyc_i, cti_i, bte_i,
        output dat_o, ack_o, err_o
    );
endinterface

// File: rtl/wb_burst_ram.sv
// Wishbone B4 RAM slave: registered-feedback CTI/BTE bursts, programmable first-beat
// wait states and error termination for word indices beyond DEPTH_WORDS.
module wb_burst_ram #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ADDR_WIDTH  = 32,
    parameter int unsigned SEL_WIDTH   = DATA_WIDTH / 8,
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned WAIT_STATES = 0,
    parameter bit          BURST_EN    = 1'b1
) (
    input logic           clk,
    input logic           rst_n,
    wb_burst_ram_if.slave bus
);
    localparam int unsigned LSB      = (SEL_WIDTH > 1) ? $clog2(SEL_WIDTH) : 0;
    // One spare bit so a linear increment past the top can be seen as out of range.
    localparam int unsigned IDX_BITS = ADDR_WIDTH - LSB + 1;
    localparam int unsigned MEM_AW   = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [IDX_BITS-1:0] DEPTH_L   = IDX_BITS'(DEPTH_WORDS);
    localparam logic [IDX_BITS-1:0] IDX_ONE   = IDX_BITS'(1);
    localparam logic [3:0]          WAIT_LAST = 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StBeat, StBurst} state_e;

    logic [DATA_WIDTH-1:0] mem [DEPTH_WORDS];

    state_e                state_q;
    logic [3:0]            wait_cnt_q;
    logic [IDX_BITS-1:0]   idx_q;
    logic                  lat_we_q;
    logic [2:0]            lat_cti_q;
    logic [1:0]            lat_bte_q;
    logic                  ack_q;
    logic                  err_q;
    logic [DATA_WIDTH-1:0] dat_q;

    logic                  req;
    logic [IDX_BITS-1:0]   adr_idx;
    logic [IDX_BITS-1:0]   nxt_idx;
    logic [IDX_BITS-1:0]   pre_idx;
    logic                  pre_ok;
    logic [DATA_WIDTH-1:0] pre_data;
    logic                  wr_en;
    logic                  burst_go;

    assign req     = bus.cyc_i & bus.stb_i;
    assign adr_idx = {1'b0, bus.adr_i[ADDR_WIDTH-1:LSB]};

    if (LSB > 0) begin : g_lane_bits
        logic unused_adr_lsb;
        assign unused_adr_lsb = ^bus.adr_i[LSB-1:0];
    end

    always_comb begin
        case (lat_bte_q)
            2'b01:   nxt_idx = {idx_q[IDX_BITS-1:2], idx_q[1:0] + 2'd1};
            2'b10:   nxt_idx = {idx_q[IDX_BITS-1:3], idx_q[2:0] + 3'd1};
            2'b11:   nxt_idx = {idx_q[IDX_BITS-1:4], idx_q[3:0] + 4'd1};
            default: nxt_idx = idx_q + IDX_ONE;
        endcase
    end

    // Word whose data is fetched into dat_q at the coming edge for the next ack.
    always_comb begin
        pre_idx = nxt_idx;
        if (state_q == StIdle) begin
            pre_idx = adr_idx;
        end else if (state_q == StWait) begin
            pre_idx = idx_q;
        end
    end

    assign pre_ok   = pre_idx < DEPTH_L;
    assign pre_data = mem[pre_idx[MEM_AW-1:0]];
    assign burst_go = BURST_EN && ack_q && (lat_cti_q == 3'b010);

    // A write commits on the edge that completes an acked beat; the read was already taken.
    always_comb begin
        wr_en = 1'b0;
        if (req && ack_q) begin
            if (state_q == StBeat) begin
                wr_en = lat_we_q;
            end else if (state_q == StBurst) begin
                wr_en = bus.we_i;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int k = 0; k < int'(SEL_WIDTH); k++) begin
                if (bus.sel_i[k]) begin
                    mem[idx_q[MEM_AW-1:0]][8*k +: 8] <= bus.dat_i[8*k +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            wait_cnt_q <= '0;
            idx_q      <= '0;
            lat_we_q   <= 1'b0;
            lat_cti_q  <= '0;
            lat_bte_q  <= '0;
            ack_q      <= 1'b0;
            err_q      <= 1'b0;
            dat_q      <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        idx_q      <= adr_idx;
                        lat_we_q   <= bus.we_i;
                        lat_cti_q  <= bus.cti_i;
                        lat_bte_q  <= bus.bte_i;
                        wait_cnt_q <= '0;
                        if (WAIT_STATES == 0) begin
                            state_q <= StBeat;
                            ack_q   <= pre_ok;
                            err_q   <= !pre_ok;
                            if (pre_ok) dat_q <= pre_data;
                        end else begin
                            state_q <= StWait;
                        end
                    end
                end
                StWait: begin
                    if (!bus.cyc_i) begin
                        state_q    <= StIdle;
                        wait_cnt_q <= '0;
                    end else if (wait_cnt_q == WAIT_LAST) begin
                        state_q    <= StBeat;
                        wait_cnt_q <= '0;
                        ack_q      <= pre_ok;
                        err_q      <= !pre_ok;
                        if (pre_ok) dat_q <= pre_data;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 4'd1;
                    end
                end
                StBeat: begin
                    if (!bus.cyc_i) begin
                        state_q <= StIdle;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end else if (bus.stb_i) begin
                        if (burst_go) begin
                            state_q <= StBurst;
                            idx_q   <= nxt_idx;
                            ack_q   <= pre_ok;
                            err_q   <= !pre_ok;
                            if (pre_ok) dat_q <= pre_data;
                        end else begin
                            state_q <= StIdle;
                            ack_q   <= 1'b0;
                            err_q   <= 1'b0;
                        end
                    end
                end
                StBurst: begin
                    // stb_i low with cyc_i high is a pause: everything holds.
                    if (!bus.cyc_i || (bus.stb_i && (err_q || bus.cti_i == 3'b111))) begin
                        state_q <= StIdle;
                        ack_q   <= 1'b0;
                        err_q   <= 1'b0;
                    end else if (bus.stb_i) begin
                        idx_q <= nxt_idx;
                        ack_q <= pre_ok;
                        err_q <= !pre_ok;
                        if (pre_ok) dat_q <= pre_data;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    // Terminations are prefetched; they only reach the bus while the master strobes.
    assign bus.ack_o = ack_q & bus.cyc_i & bus.stb_i;
    assign bus.err_o = err_q & bus.cyc_i & bus.stb_i;
    assign bus.dat_o = dat_q;
endmodule

// File: tb/tb_wb_burst_ram.sv
// Scoreboarded bench for wb_burst_ram: three instances (no wait states, three wait
// states, eight-word depth) share one master; a monitor checks every termination.
module tb_wb_burst_ram;
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    logic [31:0] m_adr;
    logic [63:0] m_dat;
    logic        m_we;
    logic [7:0]  m_sel;
    logic        m_stb;
    logic        m_cyc;
    logic [2:0]  m_cti;
    logic [1:0]  m_bte;
    logic [1:0]  dsel;

    logic        ack_m;
    logic        err_m;
    logic [63:0] dat_m;

    wb_burst_ram_if if0 ();
    wb_burst_ram_if if1 ();
    wb_burst_ram_if if2 ();

    assign if0.adr_i = m_adr;
    assign if0.dat_i = m_dat;
    assign if0.we_i  = m_we;
    assign if0.sel_i = m_sel;
    assign if0.cti_i = m_cti;
    assign if0.bte_i = m_bte;
    assign if0.cyc_i = m_cyc & (dsel == 2'd0);
    assign if0.stb_i = m_stb & (dsel == 2'd0);
    assign if1.adr_i = m_adr;
    assign if1.dat_i = m_dat;
    assign if1.we_i  = m_we;
    assign if1.sel_i = m_sel;
    assign if1.cti_i = m_cti;
    assign if1.bte_i = m_bte;
    assign if1.cyc_i = m_cyc & (dsel == 2'd1);
    assign if1.stb_i = m_stb & (dsel == 2'd1);
    assign if2.adr_i = m_adr;
    assign if2.dat_i = m_dat;
    assign if2.we_i  = m_we;
    assign if2.sel_i = m_sel;
    assign if2.cti_i = m_cti;
    assign if2.bte_i = m_bte;
    assign if2.cyc_i = m_cyc & (dsel == 2'd2);
    assign if2.stb_i = m_stb & (dsel == 2'd2);

    wb_burst_ram #(.WAIT_STATES(0)) u_dut0 (.clk(clk), .rst_n(rst_n), .bus(if0));
    wb_burst_ram #(.WAIT_STATES(3)) u_dut1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    wb_burst_ram #(.DEPTH_WORDS(8)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(if2));

    always_comb begin
        ack_m = if0.ack_o;
        err_m = if0.err_o;
        dat_m = if0.dat_o;
        if (dsel == 2'd1) begin
            ack_m = if1.ack_o;
            err_m = if1.err_o;
            dat_m = if1.dat_o;
        end else if (dsel == 2'd2) begin
            ack_m = if2.ack_o;
            err_m = if2.err_o;
            dat_m = if2.dat_o;
        end
    end

    typedef struct {
        string       tag;
        logic        is_err;
        logic [63:0] data;
        logic        chk;
        int          cyc;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    logic [63:0] bd [8];
    logic [63:0] ed [8];
    logic        ek [8];
    logic        ec [8];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic exp_push(input string tag, input logic is_err, input logic [63:0] d,
                            input logic chk, input int cyc);
        exp_t e;
        e.tag = tag;
        e.is_err = is_err;
        e.data = d;
        e.chk = chk;
        e.cyc = cyc;
        sb.push_back(e);
    endtask

    // Monitor: every ack/err seen on the selected DUT consumes one scoreboard entry.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (ack_m || err_m) begin
                if (sb.size() == 0) begin
                    check("unexpected_term", {62'd0, ack_m, err_m}, 64'd0);
                end else begin
                    e = sb.pop_front();
                    check({e.tag, "_kind"}, {62'd0, ack_m, err_m}, {62'd0, !e.is_err, e.is_err});
                    check({e.tag, "_cycle"}, 64'(cycle), 64'(e.cyc));
                    if (e.chk) check({e.tag, "_data"}, dat_m, e.data);
                end
            end
        end
    end

    task automatic wait_term(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ack_m || err_m) && n < 50);
        if (!(ack_m || err_m)) check({tag, "_timeout"}, {63'd0, ack_m | err_m}, 64'd1);
    endtask

    task automatic single(input string tag, input logic [31:0] a, input logic w,
                          input logic [7:0] s, input logic [63:0] d, input logic is_err,
                          input logic [63:0] ex, input logic chk, input int ws);
        @(posedge clk);
        #1;
        exp_push(tag, is_err, ex, chk, cycle + 1 + ws);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_adr = a; m_sel = s; m_dat = d;
        m_cti = 3'b000; m_bte = 2'b00;
        wait_term(tag);
        @(posedge clk);
        #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
    endtask

    task automatic burst(input string tag, input logic [31:0] a, input logic [1:0] bt,
                         input int n, input logic w, input int gap_after, input int gap_len,
                         input int ws);
        int beat = 0;
        int budget = 0;
        int c0;
        @(posedge clk);
        #1;
        c0 = cycle;
        for (int k = 0; k < n; k++) begin
            exp_push($sformatf("%s_b%0d", tag, k), ek[k], ed[k], ec[k],
                     c0 + 1 + ws + k + ((gap_after >= 0 && k > gap_after) ? gap_len : 0));
        end
        m_cyc = 1'b1; m_stb = 1'b1; m_we = w; m_adr = a; m_bte = bt; m_sel = '1;
        m_dat = bd[0];
        m_cti = (n == 1) ? 3'b111 : 3'b010;
        while (beat < n && budget < 200) begin
            @(negedge clk);
            budget++;
            if (ack_m || err_m) begin
                beat = err_m ? n : beat + 1;
                @(posedge clk);
                #1;
                if (beat < n) begin
                    if (beat - 1 == gap_after) begin
                        m_stb = 1'b0;
                        repeat (gap_len) begin
                            @(posedge clk);
                            #1;
                        end
                        m_stb = 1'b1;
                    end
                    m_dat = bd[beat];
                    m_cti = (beat == n - 1) ? 3'b111 : 3'b010;
                end
            end else begin
                @(posedge clk);
                #1;
            end
        end
        if (beat < n) check({tag, "_timeout"}, 64'(beat), 64'(n));
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0; m_cti = 3'b000; m_bte = 2'b00;
    endtask

    initial begin
        int c;
        rst_n = 1'b0;
        m_adr = '0; m_dat = '0; m_we = 1'b0; m_sel = '1; m_stb = 1'b0; m_cyc = 1'b0;
        m_cti = '0; m_bte = '0; dsel = 2'd0;
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        for (int d = 0; d < 3; d++) begin
            dsel = 2'(d);
            #1;
            check($sformatf("rst%0d_ack", d), {63'd0, ack_m}, 64'd0);
            check($sformatf("rst%0d_err", d), {63'd0, err_m}, 64'd0);
            check($sformatf("rst%0d_dat", d), dat_m, 64'd0);
        end

        // No wait states, 4096 words.
        dsel = 2'd0;
        single("w10", 32'h10, 1'b1, 8'hFF, 64'h1122334455667788, 1'b0, '0, 1'b0, 0);
        single("r10", 32'h10, 1'b0, 8'hFF, '0, 1'b0, 64'h1122334455667788, 1'b1, 0);
        single("w18_clr", 32'h18, 1'b1, 8'hFF, '0, 1'b0, '0, 1'b0, 0);
        single("w18_lo", 32'h18, 1'b1, 8'h0F, '1, 1'b0, '0, 1'b1, 0);
        single("r18", 32'h18, 1'b0, 8'hFF, '0, 1'b0, 64'h00000000FFFFFFFF, 1'b1, 0);

        for (int k = 0; k < 4; k++) begin
            bd[k] = 64'(k + 1); ek[k] = 1'b0; ec[k] = 1'b0; ed[k] = '0;
        end
        burst("lin_wr", 32'h20, 2'b00, 4, 1'b1, 1, 2, 0);
        for (int k = 0; k < 4; k++) begin
            ed[k] = 64'(k + 1); ec[k] = 1'b1;
        end
        burst("lin_rd", 32'h20, 2'b00, 4, 1'b0, -1, 0, 0);
        ed[0] = 64'd3; ed[1] = 64'd4; ed[2] = 64'd1; ed[3] = 64'd2;
        burst("wrap4_rd", 32'h30, 2'b01, 4, 1'b0, -1, 0, 0);

        // Three wait states, including an aborted write.
        dsel = 2'd1;
        single("ws_w20", 32'h20, 1'b1, 8'hFF, 64'hA5A5A5A5A5A5A5A5, 1'b0, '0, 1'b0, 3);
        single("ws_r20", 32'h20, 1'b0, 8'hFF, '0, 1'b0, 64'hA5A5A5A5A5A5A5A5, 1'b1, 3);
        @(posedge clk);
        #1;
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b1; m_adr = 32'h20; m_sel = '1;
        m_dat = 64'h5A5A5A5A5A5A5A5A; m_cti = 3'b000;
        repeat (2) begin
            @(posedge clk);
            #1;
        end
        m_cyc = 1'b0; m_stb = 1'b0; m_we = 1'b0;
        repeat (8) @(posedge clk);
        single("ws_r20_post", 32'h20, 1'b0, 8'hFF, '0, 1'b0, 64'hA5A5A5A5A5A5A5A5, 1'b1, 3);

        // Eight-word instance: range errors.
        dsel = 2'd2;
        single("d8_w6", 32'h30, 1'b1, 8'hFF, 64'h66, 1'b0, '0, 1'b0, 0);
        single("d8_w7", 32'h38, 1'b1, 8'hFF, 64'h77, 1'b0, '0, 1'b0, 0);
        single("d8_r7", 32'h38, 1'b0, 8'hFF, '0, 1'b0, 64'h77, 1'b1, 0);
        single("d8_r9", 32'h48, 1'b0, 8'hFF, '0, 1'b1, 64'h77, 1'b1, 0);
        ek[0] = 1'b0; ek[1] = 1'b0; ek[2] = 1'b1;
        ed[0] = 64'h66; ed[1] = 64'h77; ed[2] = 64'h77;
        ec[0] = 1'b1; ec[1] = 1'b1; ec[2] = 1'b1;
        burst("d8_lin", 32'h30, 2'b00, 3, 1'b0, -1, 0, 0);

        // Reset while a burst is mid-flight.
        @(posedge clk);
        #1;
        c = cycle;
        exp_push("rstb_b0", 1'b0, '0, 1'b0, c + 1);
        exp_push("rstb_b1", 1'b0, '0, 1'b0, c + 2);
        m_cyc = 1'b1; m_stb = 1'b1; m_we = 1'b0; m_adr = 32'h0; m_cti = 3'b010; m_bte = 2'b00;
        repeat (3) @(posedge clk);
        #1;
        check("rstb_pre_ack", {63'd0, ack_m}, 64'd1);
        rst_n = 1'b0;
        #1;
        check("rstb_ack_low", {63'd0, ack_m}, 64'd0);
        check("rstb_err_low", {63'd0, err_m}, 64'd0);
        check("rstb_dat_zero", dat_m, 64'd0);
        @(posedge clk);
        #1;
        m_cyc = 1'b0; m_stb = 1'b0; m_cti = 3'b000;
        rst_n = 1'b1;
        single("post_rst_r7", 32'h38, 1'b0, 8'hFF, '0, 1'b0, 64'h77, 1'b1, 0);

        repeat (5) @(posedge clk);
        check("sb_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
